uart_tx_bus: RTL
================

# uart_tx_bus

Memory-mapped UART transmitter that sits on the system bus as a responder, opposite the CPU's initiator port. It accepts word-addressed register reads and writes with byte enables and returns read data one cycle later with `bus_read_data_valid`. Bytes written to the DATA register are queued in a small FIFO and serialized on `tx` as 8N1 frames at a programmable bit period.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.
- `CLKS_PER_BIT_DEFAULT`, 16'd434: reset value of DIVISOR.
- `clk` in 1: single clock; all logic rises on posedge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `bus_ready` out 1: responder can accept a request this cycle.
- `bus_addr` in 30: word address; only `[1:0]` decoded, upper bits decoded externally.
- `bus_write_data` in 32: write data.
- `bus_byte_enable` in 4: byte lanes for writes; ignored on reads.
- `bus_write_req` in 1: write request.
- `bus_read_req` in 1: read request.
- `bus_read_data` out 32: read data, meaningful only when valid.
- `bus_read_data_valid` out 1: one pulse per accepted read.
- `tx` out 1: serial output, idle high.

## Operation
- Acceptance: a request is accepted on a posedge where `bus_ready` and (`bus_write_req` or `bus_read_req`). If both are high, only the write takes effect and no read data is returned.
- `bus_ready` is registered: 0 in reset, then 1 from the first posedge after reset release. It never drops afterwards.
- Register map by `bus_addr[1:0]`:
  - 0 DATA.
    - Write with `byte_enable[0]`=1 pushes `write_data[7:0]`. Other lanes are ignored.
    - Read returns 0.
  - 1 STATUS (read-only; writes ignored).
    - bit0 full (count==FIFO_DEPTH).
    - bit1 empty (count==0).
    - bit2 busy (shifter not IDLE or count!=0).
    - bit3 overflow (sticky).
    - bits[12:8] count.
    - Others 0.
    - A read clears overflow, unless an overflowing push is accepted in the same cycle; set wins.
  - 2 DIVISOR, 16 bits, r/w.
    - `byte_enable[0]` writes `[7:0]` and `byte_enable[1]` writes `[15:8]`.
    - Reads return zero-extended.
  - 3 reserved: reads 0, writes ignored.
- FIFO overflow:
  - A push when count==FIFO_DEPTH is dropped and sets overflow.
  - Fullness uses the registered count, even if the shifter pops in the same cycle.
- Shifter FSM (IDLE, START, DATA, STOP):
  - IDLE:
    - If count!=0: pop the head into the shift register, latch bit period = max(DIVISOR,1) into the period register, and go to START.
    - Otherwise stay.
  - START: `tx`=0 for period cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[index], LSB first, each for period cycles. After index 7 go to STOP.
  - STOP: `tx`=1 for period cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between STOP end and the next START.
- DIVISOR changes affect only frames started afterwards.
- Bit counter: 16 bits; counts from period-1 down to 0; wrap loads the next bit.
- Count arithmetic:
  - Simultaneous push and pop: count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - `bus_ready`=0, `bus_read_data`=0, `bus_read_data_valid`=0, `tx`=1.
  - FIFO empty, overflow=0, DIVISOR=CLKS_PER_BIT_DEFAULT, FSM IDLE.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously.
  - FIFO contents and any pending read are discarded; no `bus_read_data_valid` is issued for them.
- Read latency is fixed at 1:
  - A read accepted at edge N produces `bus_read_data_valid`=1 with data for cycle N+1 only.
  - Data reflects register state before edge N's updates.
  - `bus_read_data` holds its last value otherwise.
- Write to DATA:
  - Write accepted at edge N gives count+1 after N.
  - If the shifter is IDLE and the FIFO was empty, the pop occurs at edge N+1 and `tx` falls after edge N+1.
- Frame length: 10×period cycles, plus 1 IDLE cycle between consecutive frames.
- Pipelined reads on consecutive cycles return valid on consecutive cycles, in order.

## Test plan
- Reset, then DIVISOR write 4 (be=0011), then DATA write 0xA5:
  - `tx` is low 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then high 4 cycles: 40 cycles total.
  - STATUS then reads 0x00000002.
- DIVISOR=0, write 0x00: 10-cycle frame, each bit 1 cycle (period clamps to 1).
- Divisor 100, write FIFO_DEPTH+2 bytes back-to-back:
  - After the first pop, one byte is dropped.
  - STATUS shows full=1, overflow=1, count=8.
  - A second STATUS read shows overflow=0.
  - All queued bytes are sent in order, with 1 IDLE cycle between frames.
- Read STATUS, DIVISOR, reserved, DATA on four consecutive cycles:
  - Four valid pulses on consecutive cycles.
  - Values: status, 0x1B2 (after writing 434), 0, 0.
- Write DATA with be=1110: no push, count stays 0, `tx` stays 1.
- Assert `reset_n` low during DATA bit 3: `tx`=1 immediately; after release STATUS=0x00000002 and DIVISOR=CLKS_PER_BIT_DEFAULT.

Source files
------------

// File: rtl/uart_tx_bus.sv
// Memory-mapped 8N1 UART transmitter, bus responder side.
//
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   bus_ready               registered; high from the first edge after reset release
//   bus_addr[1:0]           register select (0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved)
//   bus_write_data          write data
//   bus_byte_enable         write lanes (ignored on reads)
//   bus_write_req           write request (wins over a simultaneous read)
//   bus_read_req            read request
//   bus_read_data           read data, held between reads
//   bus_read_data_valid     one-cycle pulse, one cycle after an accepted read
//   tx                      serial output, idle high
//
// Bytes written to DATA are queued in a FIFO and sent LSB first as
// start + 8 data + stop, each bit lasting max(DIVISOR,1) clocks.
module uart_tx_bus #(
  parameter int unsigned FIFO_DEPTH           = 8,
  parameter logic [15:0] CLKS_PER_BIT_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        bus_ready,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_write_req,
  input  logic        bus_read_req,
  output logic [31:0] bus_read_data,
  output logic        bus_read_data_valid,
  output logic        tx
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [15:0]       period_q, period_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [4:0]        count5;

  logic              ready_q;
  logic              ovf_q;
  logic [15:0]       div_q;
  logic [31:0]       rdata_q, rd_mux;
  logic              rvalid_q;

  logic [1:0]        addr;
  logic              wr_acc, rd_acc;
  logic              full, empty, busy;
  logic              push_req, push, ovf_set, pop;
  logic [31:0]       status;

  // Upper address bits are decoded outside; unused lanes are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus_addr[29:2], bus_write_data[31:16], bus_byte_enable[3:2]};

  assign addr   = bus_addr[1:0];
  assign wr_acc = ready_q & bus_write_req;
  assign rd_acc = ready_q & bus_read_req & ~bus_write_req;

  // Fullness is judged on the registered count, even if a pop happens this edge.
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle) | ~empty;
  assign push_req = wr_acc & (addr == 2'd0) & bus_byte_enable[0];
  assign push     = push_req & ~full;
  assign ovf_set  = push_req & full;

  assign count5 = 5'(count_q);
  assign status = {19'b0, count5, 4'b0, ovf_q, busy, empty, full};

  always_comb begin
    rd_mux = 32'b0;
    unique case (addr)
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {16'b0, div_q};
      default: rd_mux = 32'b0;
    endcase
  end

  // Shifter next-state and serial output.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    tx        = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          period_d  = (div_q == 16'd0) ? 16'd1 : div_q;
          bit_cnt_d = period_d - 16'd1;
          state_d   = StStart;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = period_q - 16'd1;
          idx_d     = 3'd0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StData: begin
        tx = shift_q[idx_q];
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = period_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StStop: begin
        tx = 1'b1;
        if (bit_cnt_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      period_q  <= 16'd1;
      bit_cnt_q <= 16'd0;
      shift_q   <= 8'd0;
      idx_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
    end
  end

  // FIFO storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= CLKS_PER_BIT_DEFAULT;
      rdata_q  <= 32'b0;
      rvalid_q <= 1'b0;
    end else begin
      ready_q  <= 1'b1;
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_mux;
      // Set wins over the read-to-clear.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (rd_acc && addr == 2'd1) begin
        ovf_q <= 1'b0;
      end
      if (wr_acc && addr == 2'd2) begin
        if (bus_byte_enable[0]) div_q[7:0]  <= bus_write_data[7:0];
        if (bus_byte_enable[1]) div_q[15:8] <= bus_write_data[15:8];
      end
    end
  end

  assign bus_ready           = ready_q;
  assign bus_read_data       = rdata_q;
  assign bus_read_data_valid = rvalid_q;

endmodule
